// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and fetch-time PC copy for the multicycle datapath.
// Decodes the latched instruction into the fields consumed by control and the register file.
module fetch_pc_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] MemData,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] RegA,
    input  logic             Zero,
    input  logic             IRegWrite,
    input  logic             PCWrite,
    input  logic             PCWriteBeq,
    input  logic             PCWriteBne,
    input  logic [1:0]       PCData,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] OldPC,
    output logic [WIDTH-1:0] Instr,
    output logic [3:0]       Opcode,
    output logic [3:0]       Rd,
    output logic [3:0]       Rs,
    output logic [3:0]       Rt,
    output logic [7:0]       Imm,
    output logic [WIDTH-1:0] JumpTarget,
    output logic             Misalign,
    output logic [15:0]      InstrCount
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] old_pc_q, old_pc_d;
    logic             misalign_q, misalign_d;
    logic [15:0]      instr_count_q, instr_count_d;

    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;
    logic             pc_en;

    // Jump target keeps the top PC bits of the current region and word-aligns the offset.
    assign jump_target = {pc_q[WIDTH-1:WIDTH-3], ir_q[WIDTH-5:0], 1'b0};

    always_comb begin
        next_pc = ALUResult;
        unique case (PCData)
            2'b00:   next_pc = ALUResult;
            2'b01:   next_pc = ALUOut;
            2'b10:   next_pc = jump_target;
            2'b11:   next_pc = RegA;
            default: next_pc = ALUResult;
        endcase
    end

    assign pc_en = PCWrite | (PCWriteBeq & Zero) | (PCWriteBne & ~Zero);

    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        old_pc_d      = old_pc_q;
        misalign_d    = misalign_q;
        instr_count_d = instr_count_q;

        if (pc_en) begin
            pc_d = {next_pc[WIDTH-1:1], 1'b0};
            if (next_pc[0]) begin
                misalign_d = 1'b1;
            end
        end

        // OldPC takes the pre-update PC even when the PC is written in the same cycle.
        if (IRegWrite) begin
            ir_d          = MemData;
            old_pc_d      = pc_q;
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q          <= RESET_VECTOR;
            ir_q          <= '0;
            old_pc_q      <= '0;
            misalign_q    <= 1'b0;
            instr_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            old_pc_q      <= old_pc_d;
            misalign_q    <= misalign_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign PC         = pc_q;
    assign OldPC      = old_pc_q;
    assign Instr      = ir_q;
    assign Opcode     = ir_q[WIDTH-1 -: 4];
    assign Rd         = ir_q[11:8];
    assign Rs         = ir_q[7:4];
    assign Rt         = ir_q[3:0];
    assign Imm        = ir_q[7:0];
    assign JumpTarget = jump_target;
    assign Misalign   = misalign_q;
    assign InstrCount = instr_count_q;

endmodule
